// File: rtl/alu_seq_pkg.sv
// Shared types for the handshaked EX-stage ALU: op codes, FSM states, multi-cycle op decode.
// Build option: define ALU_SEQ_DIV_EN to add the iterative DIVU/REMU datapath.
package alu_seq_pkg;

    localparam int OP_WIDTH = 4;

    typedef enum logic [OP_WIDTH-1:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_MUL   = 4'b1010,
        ALU_MULHU = 4'b1011,
        ALU_DIVU  = 4'b1100,
        ALU_REMU  = 4'b1101,
        ALU_RSV_E = 4'b1110,
        ALU_RSV_F = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1
`ifdef ALU_SEQ_DIV_EN
        ,
        DIV  = 2'd2
`endif
    } alu_state_e;

    function automatic logic is_multicycle(alu_op_e op);
        logic mc;
        mc = 1'b0;
        case (op)
            ALU_MUL, ALU_MULHU: mc = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            ALU_DIVU, ALU_REMU: mc = 1'b1;
`endif
            default: mc = 1'b0;
        endcase
        return mc;
    endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Purely combinational single-cycle result mux of the EX-stage ALU.
// Multi-cycle codes (and undecoded ones) produce 0 here; the top handles them.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  alu_op_e               op,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

    logic [SHAMT_WIDTH-1:0] shamt;
    assign shamt = op2[SHAMT_WIDTH-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = op1 + op2;
            ALU_SUB:  result = op1 - op2;
            ALU_AND:  result = op1 & op2;
            ALU_OR:   result = op1 | op2;
            ALU_XOR:  result = op1 ^ op2;
            ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
            ALU_SLL:  result = op1 << shamt;
            ALU_SRL:  result = op1 >> shamt;
            ALU_SRA:  result = $unsigned($signed(op1) >>> shamt);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: single-cycle ops land in the output slot at the accept edge,
// MUL/MULHU iterate one bit per cycle. Define ALU_SEQ_DIV_EN to add DIVU/REMU.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [CTRL_WIDTH-1:0] alu_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic                  zero,
    output logic                  busy
);

    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [SHAMT_WIDTH-1:0] LAST_COUNT = SHAMT_WIDTH'(DATA_WIDTH - 1);

    alu_state_e                state_q, state_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]     alu_out_q, alu_out_d;
    logic                      zero_q, zero_d;
    logic                      zero_pend_q, zero_pend_d;
    logic [SHAMT_WIDTH-1:0]    counter_q, counter_d;
    logic [2*DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [DATA_WIDTH-1:0]     opnd_q, opnd_d;
    alu_op_e                   op_q, op_d;

    // Codes wider than the 4-bit op space decode as an unknown op (result 0).
    logic [CTRL_WIDTH+3:0] ctrl_wide;
    alu_op_e               in_op;
    assign ctrl_wide = {4'b0000, alu_ctrl};
    assign in_op     = (ctrl_wide > (CTRL_WIDTH+4)'(15)) ? ALU_RSV_F : alu_op_e'(ctrl_wide[3:0]);

    logic [DATA_WIDTH-1:0] comb_result;

    alu_seq_comb #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_comb (
        .op1    (op1),
        .op2    (op2),
        .op     (in_op),
        .result (comb_result)
    );

    logic slot_free;
    logic accept;
    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == IDLE) && slot_free;
    assign accept    = in_valid && in_ready;

    // Shift-add: acc = {partial_hi, multiplier_lo}; add multiplicand on lsb, shift right.
    logic [DATA_WIDTH:0]     mul_sum;
    logic [2*DATA_WIDTH-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, {DATA_WIDTH{acc_q[0]}} & opnd_q};
    assign mul_step = {mul_sum, acc_q[DATA_WIDTH-1:1]};

    logic [2*DATA_WIDTH-1:0] iter_step;

`ifdef ALU_SEQ_DIV_EN
    // Restoring division: acc = {remainder, quotient}. A zero divisor always "fits",
    // which naturally yields all-ones quotient and the dividend as remainder.
    logic [DATA_WIDTH:0]     div_shift;
    logic [DATA_WIDTH-1:0]   div_diff;
    logic                    div_ge;
    logic [2*DATA_WIDTH-1:0] div_step;
    assign div_shift = {acc_q[2*DATA_WIDTH-1:DATA_WIDTH], acc_q[DATA_WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[DATA_WIDTH-1:0] - opnd_q;
    assign div_step  = div_ge ? {div_diff, acc_q[DATA_WIDTH-2:0], 1'b1}
                              : {div_shift[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b0};
    assign iter_step = (state_q == DIV) ? div_step : mul_step;
`else
    assign iter_step = mul_step;
`endif

    logic [DATA_WIDTH-1:0] iter_result;
    always_comb begin
        iter_result = iter_step[DATA_WIDTH-1:0];
        if (op_q == ALU_MULHU || op_q == ALU_REMU) begin
            iter_result = iter_step[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        alu_out_d   = alu_out_q;
        zero_d      = zero_q;
        zero_pend_d = zero_pend_q;
        counter_d   = counter_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        op_d        = op_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q == IDLE) begin
            if (accept) begin
                if (is_multicycle(in_op)) begin
                    op_d        = in_op;
                    zero_pend_d = (op1 == op2);
                    counter_d   = '0;
                    state_d     = MUL;
                    opnd_d      = op1;
                    acc_d       = {{DATA_WIDTH{1'b0}}, op2};
`ifdef ALU_SEQ_DIV_EN
                    if (in_op == ALU_DIVU || in_op == ALU_REMU) begin
                        state_d = DIV;
                        opnd_d  = op2;
                        acc_d   = {{DATA_WIDTH{1'b0}}, op1};
                    end
`endif
                end else begin
                    alu_out_d   = comb_result;
                    zero_d      = (op1 == op2);
                    out_valid_d = 1'b1;
                end
            end
        end else if (counter_q != LAST_COUNT) begin
            acc_d     = iter_step;
            counter_d = counter_q + 1'b1;
        end else if (slot_free) begin
            // Final bit: publish only when the slot can take it, otherwise hold here.
            acc_d       = iter_step;
            counter_d   = '0;
            alu_out_d   = iter_result;
            zero_d      = zero_pend_q;
            out_valid_d = 1'b1;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            zero_q      <= 1'b0;
            zero_pend_q <= 1'b0;
            counter_q   <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            op_q        <= ALU_ADD;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            zero_q      <= zero_d;
            zero_pend_q <= zero_pend_d;
            counter_q   <= counter_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            op_q        <= op_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign zero      = zero_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; DIVU/REMU scenarios run when ALU_SEQ_DIV_EN is defined.
module tb_alu_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op1;
    logic [W-1:0]  op2;
    logic [3:0]    alu_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  alu_out;
    logic          zero;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq #(
        .DATA_WIDTH (W),
        .CTRL_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .zero      (zero),
        .busy      (busy)
    );

    // Directed single-cycle vectors: ctrl, op1, op2, expected result, expected zero
    localparam int NV = 13;
    bit [3:0]  tv_ctrl [NV] = '{4'h1, 4'h9, 4'h5, 4'h6, 4'h6, 4'h7, 4'h8, 4'h2, 4'h3, 4'h4, 4'h0, 4'h1, 4'hF};
    bit [31:0] tv_a    [NV] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1,
                                32'h8000_0000, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hAAAA_5555,
                                32'hFFFF_FFFF, 32'd0, 32'd1};
    bit [31:0] tv_b    [NV] = '{32'd5, 32'd4, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'h3F, 32'd4,
                                32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFFFF_0000, 32'd1, 32'd1, 32'd2};
    bit [31:0] tv_exp  [NV] = '{32'd0, 32'hF800_0000, 32'd1, 32'd1, 32'd0, 32'h8000_0000,
                                32'h0800_0000, 32'hF000_F000, 32'hFFFF_FFFF, 32'h5555_5555,
                                32'd0, 32'hFFFF_FFFF, 32'd0};
    bit        tv_zero [NV] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op1 = '0; op2 = '0; alu_ctrl = 4'h0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (alu_out !== 32'd0) begin n_bad++; $display("FAIL reset_alu_out got %h want 0", alu_out); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero got %b want 0", zero); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        $display("reset: out_valid=%b alu_out=%h busy=%b", out_valid, alu_out, busy);
    endtask

    task automatic test_add();
        alu_ctrl = 4'h0; op1 = 32'h7FFF_FFFF; op2 = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_in_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_out_valid got %b want 1", out_valid); end
        n_cmp++; if (alu_out !== 32'h8000_0000) begin n_bad++; $display("FAIL add_result got %h want 80000000", alu_out); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL add_zero got %b want 0", zero); end
        $display("add: 7fffffff+1 -> %h zero=%b", alu_out, zero);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            alu_ctrl = tv_ctrl[i]; op1 = tv_a[i]; op2 = tv_b[i]; in_valid = 1'b1;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
            n_cmp++; if (alu_out !== tv_exp[i]) begin n_bad++; $display("FAIL b2b_result[%0d] ctrl=%h got %h want %h", i, tv_ctrl[i], alu_out, tv_exp[i]); end
            n_cmp++; if (zero !== tv_zero[i]) begin n_bad++; $display("FAIL b2b_zero[%0d] got %b want %b", i, zero, tv_zero[i]); end
            $display("b2b[%0d]: ctrl=%h %h,%h -> %h zero=%b", i, tv_ctrl[i], tv_a[i], tv_b[i], alu_out, zero);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_multicycle(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] exp, input logic exp_zero);
        int cycles;
        alu_ctrl = ctrl; op1 = a; op2 = b; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        alu_ctrl = 4'h0; op1 = 32'd1; op2 = 32'd1;
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            n_cmp++; if ({busy, in_ready} !== 2'b10) begin n_bad++; $display("FAIL mc_busy ctrl=%h cyc=%0d got busy=%b in_ready=%b want 1,0", ctrl, cycles, busy, in_ready); end
            tick();
            cycles++;
        end
        n_cmp++; if (cycles !== 32) begin n_bad++; $display("FAIL mc_latency ctrl=%h got %0d want 32", ctrl, cycles); end
        n_cmp++; if (alu_out !== exp) begin n_bad++; $display("FAIL mc_result ctrl=%h got %h want %h", ctrl, alu_out, exp); end
        n_cmp++; if (zero !== exp_zero) begin n_bad++; $display("FAIL mc_zero ctrl=%h got %b want %b", ctrl, zero, exp_zero); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mc_busy_done ctrl=%h got %b want 0", ctrl, busy); end
        $display("multicycle: ctrl=%h %h,%h -> %h after %0d cycles", ctrl, a, b, alu_out, cycles);
        tick();
    endtask

    task automatic test_mul();
        test_multicycle(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        test_multicycle(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        test_multicycle(4'hA, 32'd12345, 32'd6789, 32'h04FE_D79D, 1'b0);
        test_multicycle(4'hB, 32'h8000_0000, 32'd4, 32'h0000_0002, 1'b0);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        alu_ctrl = 4'h0; op1 = 32'd3; op2 = 32'd4; in_valid = 1'b1;
        tick();
        alu_ctrl = 4'h1; op1 = 32'd100; op2 = 32'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
            n_cmp++; if (alu_out !== 32'd7) begin n_bad++; $display("FAIL bp_hold[%0d] got %h want 7", i, alu_out); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
            $display("backpressure[%0d]: out_valid=%b alu_out=%h in_ready=%b", i, out_valid, alu_out, in_ready);
            tick();
        end
        out_ready = 1'b1;
        alu_ctrl = 4'h4; op1 = 32'hF0; op2 = 32'hFF;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (alu_out !== 32'h0F || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_next got %h/%b want 0000000f/1", alu_out, out_valid); end
        $display("backpressure release: xor -> %h", alu_out);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        out_ready = 1'b1;
        alu_ctrl = 4'hA; op1 = 32'd3; op2 = 32'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rmid_abort got out_valid=%b busy=%b want 0,0", out_valid, busy); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rmid_stale got %b want 0", seen); end
        $display("reset mid-op: stale_result_seen=%b", seen);
    endtask

`ifdef ALU_SEQ_DIV_EN
    task automatic test_div();
        test_multicycle(4'hC, 32'd100, 32'd7, 32'd14, 1'b0);
        test_multicycle(4'hD, 32'd100, 32'd7, 32'd2, 1'b0);
        test_multicycle(4'hC, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b0);
        test_multicycle(4'hD, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0);
    endtask
`else
    task automatic test_div();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            alu_ctrl = (i == 0) ? 4'hC : 4'hD; op1 = 32'd100; op2 = 32'd7; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n_cmp++; if (out_valid !== 1'b1 || alu_out !== 32'd0) begin n_bad++; $display("FAIL nodiv_result[%0d] got %h/%b want 0/1", i, alu_out, out_valid); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nodiv_busy[%0d] got %b want 0", i, busy); end
            $display("no-div: ctrl=%h -> %h out_valid=%b", alu_ctrl, alu_out, out_valid);
            tick();
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_reset_mid_op();
        test_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
